collision_pair_scheduler: RTL and testbench
===========================================

COLLISION_PAIR_SCHEDULER -- requirements
Module: collision_pair_scheduler

Interface
REQ-001 SHALL have parameter N_BODIES, default 4, giving the number of bodies scanned (legal range 1..16).
REQ-002 SHALL have parameter IDX_W, default 4, giving the body index width.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port Reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begins one full pair scan when sampled high in IDLE.
REQ-006 SHALL have ports rd_idx_a and rd_idx_b, output, IDX_W bits each: body read addresses to the body register file.
REQ-007 SHALL have ports rd_body_a and rd_body_b, input, 193 bits each: combinational read data, packed MSB-first as {active, width[8], height[8], pos.x[32], pos.y[32], vel.x[24], vel.y[24], u.x[16], u.y[16], v.x[16], v.y[16]}.
REQ-008 SHALL have ports det_body_a and det_body_b, output, 192 bits each: registered body bundles without the active bit, driven to the SAT collision detector.
REQ-009 SHALL have port det_is_collision, input, 1 bit: the detector's combinational result for det_body_a/det_body_b.
REQ-010 SHALL have ports pair_valid (output, 1 bit), pair_ready (input, 1 bit), pair_a and pair_b (output, IDX_W bits each): the colliding-pair stream.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at scan completion.
REQ-013 SHALL have port hit_flags, output, N_BODIES bits: bit k is set if body k collided during the current scan.
REQ-014 SHALL have port hit_count, output, 8 bits: the number of colliding pairs found in the current scan.

Function
REQ-015 SHALL implement the states IDLE, ISSUE, EVAL, EMIT and DONE.
REQ-016 IDLE + start: SHALL clear hit_flags and hit_count, load a=0 and b=1, then go to ISSUE; if N_BODIES<2 it SHALL go to DONE instead.
REQ-017 rd_idx_a and rd_idx_b SHALL equal a and b in every state.
REQ-018 ISSUE: if both active bits are set, SHALL register the bundles into det_body_a/b and go to EVAL; otherwise SHALL skip the pair (advance, per REQ-021).
REQ-019 EVAL: SHALL sample det_is_collision. If 1, SHALL set hit_flags[a] and hit_flags[b], increment hit_count (saturating at 255) and go to EMIT; if 0, SHALL advance.
REQ-020 EMIT: SHALL hold pair_valid=1 with stable pair_a=a and pair_b=b until pair_valid&&pair_ready, then advance. A ready that is already high completes the transfer in the first EMIT cycle.
REQ-021 Advance: if b<N_BODIES-1, SHALL set b=b+1; else if a<N_BODIES-2, SHALL set a=a+1 and b=a+2; else SHALL go to DONE. Otherwise the next state SHALL be ISSUE.
REQ-022 Pair order SHALL be lexicographic (0,1),(0,2)...(N-2,N-1); each unordered pair SHALL be visited exactly once, and a pair with a==b is never issued.
REQ-023 DONE: SHALL assert done for exactly one cycle, then go to IDLE; hit_flags and hit_count SHALL hold until the next start.
REQ-024 start while busy SHALL be ignored.
REQ-025 Latency per pair SHALL be 1 cycle if skipped, 2 cycles if no collision, and 3+stall cycles if colliding.
REQ-026 pair_valid SHALL be high only in EMIT; det_body_a/b SHALL change only in ISSUE.

Reset
REQ-027 Reset_n=0 at any edge, including mid-scan or mid-EMIT, SHALL force IDLE with a=0, b=1, and zero on pair_valid, pair_a, pair_b, done, busy, hit_flags, hit_count, det_body_a and det_body_b; no partial pair SHALL be emitted after reset.

Verification
REQ-028 N=4, all bodies active, detector always 0; start -> 6 pairs visited in order, no pair_valid, done 13 cycles after start, hit_count=0.
REQ-029 N=4, detector 1 only for (1,3), pair_ready=1 -> exactly one transfer with pair_a=1 and pair_b=3, hit_flags=4'b1010, hit_count=1.
REQ-030 Same as REQ-029 but pair_ready held low for 5 cycles -> pair_valid high 6 cycles with stable indices, then the scan resumes at (2,3).
REQ-031 Body 2 inactive, detector always 1 -> pairs (0,1), (0,3), (1,3) emitted; pairs containing 2 are skipped; hit_count=3.
REQ-032 Reset_n pulsed low during EMIT of (0,2) -> next cycle IDLE, all outputs 0; a subsequent start rescans from (0,1).
REQ-033 N_BODIES=1, start -> done pulses 1 cycle later, with no reads issued and no pairs emitted.

Source files
------------

// File: rtl/collision_pair_scheduler.sv
// Walks every unordered pair of bodies, runs active pairs through the external
// SAT detector and streams colliding pairs out with ready/valid handshaking.
module collision_pair_scheduler #(
  parameter int N_BODIES = 4,
  parameter int IDX_W    = 4
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                start,
  output logic [IDX_W-1:0]    rd_idx_a,
  output logic [IDX_W-1:0]    rd_idx_b,
  input  logic [192:0]        rd_body_a,
  input  logic [192:0]        rd_body_b,
  output logic [191:0]        det_body_a,
  output logic [191:0]        det_body_b,
  input  logic                det_is_collision,
  output logic                pair_valid,
  input  logic                pair_ready,
  output logic [IDX_W-1:0]    pair_a,
  output logic [IDX_W-1:0]    pair_b,
  output logic                busy,
  output logic                done,
  output logic [N_BODIES-1:0] hit_flags,
  output logic [7:0]          hit_count
);

  typedef enum logic [2:0] {IDLE, ISSUE, EVAL, EMIT, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_B = IDX_W'(N_BODIES - 1);
  localparam logic [IDX_W-1:0] LAST_A = IDX_W'(N_BODIES - 2);

  state_t           state, state_next;
  logic [IDX_W-1:0] a, b;
  logic             both_active;
  logic             last_pair;
  logic             adv;

  function automatic logic [7:0] sat_inc(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  assign both_active = rd_body_a[192] & rd_body_b[192];
  assign last_pair   = (b >= LAST_B) && (a >= LAST_A);
  assign rd_idx_a    = a;
  assign rd_idx_b    = b;

  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // adv marks the cycle in which the current pair is finished with
  always_comb begin
    state_next = state;
    adv        = 1'b0;
    case (state)
      IDLE:    if (start) state_next = (N_BODIES < 2) ? DONE : ISSUE;
      ISSUE:   if (both_active) state_next = EVAL; else adv = 1'b1;
      EVAL:    if (det_is_collision) state_next = EMIT; else adv = 1'b1;
      EMIT:    if (pair_ready) adv = 1'b1;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (adv) state_next = last_pair ? DONE : ISSUE;
  end

  always_comb begin
    busy       = (state != IDLE);
    done       = (state == DONE);
    pair_valid = (state == EMIT);
    pair_a     = pair_valid ? a : '0;
    pair_b     = pair_valid ? b : '0;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      a          <= '0;
      b          <= IDX_W'(1);
      hit_flags  <= '0;
      hit_count  <= '0;
      det_body_a <= '0;
      det_body_b <= '0;
    end else begin
      if (state == IDLE && start) begin
        a         <= '0;
        b         <= IDX_W'(1);
        hit_flags <= '0;
        hit_count <= '0;
      end
      if (state == ISSUE && both_active) begin
        det_body_a <= rd_body_a[191:0];
        det_body_b <= rd_body_b[191:0];
      end
      if (state == EVAL && det_is_collision) begin
        for (int k = 0; k < N_BODIES; k++) begin
          if (IDX_W'(k) == a || IDX_W'(k) == b) hit_flags[k] <= 1'b1;
        end
        hit_count <= sat_inc(hit_count);
      end
      // lexicographic walk of the upper triangle
      if (adv && !last_pair) begin
        if (b < LAST_B) begin
          b <= b + IDX_W'(1);
        end else begin
          a <= a + IDX_W'(1);
          b <= a + IDX_W'(2);
        end
      end
    end
  end

endmodule

// File: tb/tb_collision_pair_scheduler.sv
// Bench for collision_pair_scheduler: body file and detector model around a
// 4-body instance, plus a 1-body instance for the degenerate scan.
module tb_collision_pair_scheduler;

  logic         Clk;
  logic         Reset_n;
  logic         start;
  logic [3:0]   rd_idx_a, rd_idx_b;
  logic [192:0] rd_body_a, rd_body_b;
  logic [191:0] det_body_a, det_body_b;
  logic         det_is_collision;
  logic         pair_valid, pair_ready;
  logic [3:0]   pair_a, pair_b;
  logic         busy, done;
  logic [3:0]   hit_flags;
  logic [7:0]   hit_count;

  logic         start1;
  logic [3:0]   rd_idx_a1, rd_idx_b1;
  logic [191:0] det_body_a1, det_body_b1;
  logic         pair_valid1;
  logic [3:0]   pair_a1, pair_b1;
  logic         busy1, done1;
  logic [0:0]   hit_flags1;
  logic [7:0]   hit_count1;

  logic [191:0] payload [16];
  logic [15:0]  act;
  logic [255:0] coll;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_pairs[$];
  logic [3:0] m_flags;
  logic [7:0] m_count;
  int         m_lat;

  bit mon_on = 0;
  int emit_no, wait_cnt, valid_cyc, cur_stall;

  typedef struct {
    logic [15:0]  act;
    logic [255:0] coll;
    int           stall;
    logic [3:0]   flags;
    logic [7:0]   count;
    int           lat;
  } vec_t;
  vec_t tab [6];

  collision_pair_scheduler #(.N_BODIES(4), .IDX_W(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start),
    .rd_idx_a(rd_idx_a), .rd_idx_b(rd_idx_b),
    .rd_body_a(rd_body_a), .rd_body_b(rd_body_b),
    .det_body_a(det_body_a), .det_body_b(det_body_b),
    .det_is_collision(det_is_collision),
    .pair_valid(pair_valid), .pair_ready(pair_ready),
    .pair_a(pair_a), .pair_b(pair_b),
    .busy(busy), .done(done),
    .hit_flags(hit_flags), .hit_count(hit_count)
  );

  collision_pair_scheduler #(.N_BODIES(1), .IDX_W(4)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start1),
    .rd_idx_a(rd_idx_a1), .rd_idx_b(rd_idx_b1),
    .rd_body_a(193'd0), .rd_body_b(193'd0),
    .det_body_a(det_body_a1), .det_body_b(det_body_b1),
    .det_is_collision(1'b0),
    .pair_valid(pair_valid1), .pair_ready(1'b1),
    .pair_a(pair_a1), .pair_b(pair_b1),
    .busy(busy1), .done(done1),
    .hit_flags(hit_flags1), .hit_count(hit_count1)
  );

  assign rd_body_a        = {act[rd_idx_a], payload[rd_idx_a]};
  assign rd_body_b        = {act[rd_idx_b], payload[rd_idx_b]};
  assign det_is_collision = coll[{det_body_a[3:0], det_body_b[3:0]}];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: walk the upper triangle, charging 1/2/3+stall cycles per pair.
  task automatic model(input logic [15:0] act_m, input logic [255:0] coll_m, input int stall_m);
    exp_pairs.delete();
    m_flags = '0;
    m_count = '0;
    m_lat   = 1;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        if (!(act_m[i] && act_m[j])) begin
          m_lat += 1;
        end else if (coll_m[i*16 + j]) begin
          m_lat += 3 + stall_m;
          exp_pairs.push_back({4'(i), 4'(j)});
          m_flags[i] = 1'b1;
          m_flags[j] = 1'b1;
          if (m_count != 8'hFF) m_count++;
        end else begin
          m_lat += 2;
        end
      end
    end
  endtask

  // Pair-stream sink: holds ready low for cur_stall cycles of each valid pair.
  always @(negedge Clk) begin
    if (mon_on && pair_valid) begin
      if (emit_no < exp_pairs.size()) begin
        check("pair_idx", {pair_a, pair_b}, exp_pairs[emit_no]);
        check("det_body_a", det_body_a, payload[pair_a]);
        check("det_body_b", det_body_b, payload[pair_b]);
      end else begin
        check("pair_overrun", emit_no, exp_pairs.size());
      end
      valid_cyc++;
      if (wait_cnt >= cur_stall) begin
        pair_ready = 1'b1;
        emit_no++;
        wait_cnt = 0;
      end else begin
        pair_ready = 1'b0;
        wait_cnt++;
      end
    end else begin
      pair_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic run_scan(input string tag, input int stall, input logic [3:0] ef,
                          input logic [7:0] ec, input int el);
    int lat;
    emit_no   = 0;
    wait_cnt  = 0;
    valid_cyc = 0;
    cur_stall = stall;
    mon_on    = 1;
    lat       = 0;
    start     = 1'b1;
    @(posedge Clk);
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge Clk);
      start = (cyc == 3);
      if (cyc == 1) check({tag, "_busy"}, busy, 1'b1);
      if (done) begin
        lat = cyc;
        break;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, lat, el);
    check({tag, "_hit_flags"}, hit_flags, ef);
    check({tag, "_hit_count"}, hit_count, ec);
    check({tag, "_emits"}, emit_no, exp_pairs.size());
    check({tag, "_valid_cycles"}, valid_cyc, exp_pairs.size() * (stall + 1));
    @(negedge Clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_flags_hold"}, hit_flags, ef);
    check({tag, "_count_hold"}, hit_count, ec);
    mon_on = 0;
  endtask

  initial begin
    logic [15:0]  act_r;
    logic [255:0] coll_r;
    int           stall_r;

    for (int k = 0; k < 16; k++) begin
      payload[k] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      payload[k][7:0] = 8'(k);
    end
    act     = 16'hFFFF;
    coll    = '0;
    Reset_n = 1'b0;
    start   = 1'b0;
    start1  = 1'b0;

    tab[0] = '{16'h000F, 256'd0,          0, 4'b0000, 8'd0, 13};
    tab[1] = '{16'h000F, 256'd1 << 19,    0, 4'b1010, 8'd1, 14};
    tab[2] = '{16'h000F, 256'd1 << 19,    5, 4'b1010, 8'd1, 19};
    tab[3] = '{16'h000B, {256{1'b1}},     0, 4'b1011, 8'd3, 13};
    tab[4] = '{16'h0000, {256{1'b1}},     0, 4'b0000, 8'd0, 7};
    tab[5] = '{16'h000F, {256{1'b1}},     1, 4'b1111, 8'd6, 25};

    repeat (3) @(negedge Clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", pair_valid, 1'b0);
    check("rst_hit_flags", hit_flags, 4'b0000);
    check("rst_hit_count", hit_count, 8'd0);
    check("rst_det_a", det_body_a, 192'd0);
    check("rst_idx", {rd_idx_a, rd_idx_b}, 8'h01);
    Reset_n = 1'b1;
    @(negedge Clk);

    for (int t = 0; t < 6; t++) begin
      act  = tab[t].act;
      coll = tab[t].coll;
      model(tab[t].act, tab[t].coll, tab[t].stall);
      run_scan($sformatf("vec%0d", t), tab[t].stall, tab[t].flags, tab[t].count, tab[t].lat);
    end

    // Reset while (0,2) sits stalled in EMIT, then rescan.
    act  = 16'h000F;
    coll = 256'd1 << 2;
    model(act, coll, 10);
    emit_no   = 0;
    wait_cnt  = 0;
    valid_cyc = 0;
    cur_stall = 10;
    mon_on    = 1;
    start     = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 50 && !pair_valid; cyc++) @(negedge Clk);
    check("pre_rst_pair", {pair_valid, pair_a, pair_b}, 9'h102);
    Reset_n = 1'b0;
    @(negedge Clk);
    mon_on = 0;
    check("mid_rst_valid", pair_valid, 1'b0);
    check("mid_rst_pair", {pair_a, pair_b}, 8'h00);
    check("mid_rst_busy_done", {busy, done}, 2'b00);
    check("mid_rst_flags", hit_flags, 4'b0000);
    check("mid_rst_count", hit_count, 8'd0);
    check("mid_rst_det", {det_body_a, det_body_b}, 384'd0);
    check("mid_rst_idx", {rd_idx_a, rd_idx_b}, 8'h01);
    Reset_n = 1'b1;
    @(negedge Clk);
    check("post_rst_valid", pair_valid, 1'b0);
    coll = 256'd1 << 1;
    model(act, coll, 0);
    run_scan("rescan", 0, m_flags, m_count, m_lat);

    for (int r = 0; r < 20; r++) begin
      act_r = 16'($urandom_range(0, 15));
      for (int w = 0; w < 8; w++) coll_r[w*32 +: 32] = $urandom;
      stall_r = $urandom_range(0, 3);
      act  = act_r;
      coll = coll_r;
      model(act_r, coll_r, stall_r);
      run_scan($sformatf("rnd%0d", r), stall_r, m_flags, m_count, m_lat);
    end

    start1 = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    start1 = 1'b0;
    check("n1_done", done1, 1'b1);
    check("n1_busy", busy1, 1'b1);
    check("n1_valid", pair_valid1, 1'b0);
    @(negedge Clk);
    check("n1_done_end", done1, 1'b0);
    check("n1_idle", busy1, 1'b0);
    check("n1_count", hit_count1, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
